cjb_8bit_sl_seq_unit_v: RTL and testbench

Sequential 8-bit shift-left/rotate-left unit. It is the left-direction companion to the ALU's combinational right shift/rotate unit. It performs logical shift left, rotate left, or rotate left through carry by 0–7 positions, moving one bit per clock under a start/done handshake. The result is registered together with the CNVZ status nibble, using the same flag ordering as the rest of the ALU, so the control unit can mux it into the ALU result path.

---
 rtl/cjb_8bit_sl_seq_unit_v_pkg.sv | 41 ++++
 rtl/cjb_sl_step_v.sv | 39 +++
 rtl/cjb_8bit_sl_seq_unit_v.sv | 150 +++++++++++++++
 tb/tb_cjb_8bit_sl_seq_unit_v.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cjb_8bit_sl_seq_unit_v_pkg.sv
// Shared definitions for the sequential shift-left/rotate-left unit:
// operation encodings, FSM state encodings, CNVZ flag bit positions and
// a helper that packs the status nibble in ALU flag order.
package cjb_8bit_sl_seq_unit_v_pkg;

  localparam int SL_DATA_W = 8;
  localparam int SL_K_W    = 3;

  typedef enum logic [1:0] {
    SL_SHL  = 2'b00,
    SL_ROL  = 2'b01,
    SL_RLC  = 2'b10,
    SL_PASS = 2'b11
  } sl_func_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } sl_state_e;

  localparam int CNVZ_C = 3;
  localparam int CNVZ_N = 2;
  localparam int CNVZ_V = 1;
  localparam int CNVZ_Z = 0;

  // Build {C,N,V,Z} from the final carry, result and sticky overflow.
  function automatic logic [3:0] make_cnvz(input logic c,
                                           input logic [SL_DATA_W-1:0] res,
                                           input logic v);
    logic [3:0] f;
    f         = '0;
    f[CNVZ_C] = c;
    f[CNVZ_N] = res[SL_DATA_W-1];
    f[CNVZ_V] = v;
    f[CNVZ_Z] = ~|res;
    return f;
  endfunction

endpackage

// File: rtl/cjb_sl_step_v.sv
// Combinational single-position left step: shift, rotate or rotate
// through carry. Also reports whether bit 7 changed across the step.
module cjb_sl_step_v
  import cjb_8bit_sl_seq_unit_v_pkg::*;
(
  input  logic [SL_DATA_W-1:0] acc,
  input  logic                 c,
  input  sl_func_e             func,
  output logic [SL_DATA_W-1:0] acc_nxt,
  output logic                 c_nxt,
  output logic                 sign_chg
);

  // One step of the selected left operation; pass holds the value.
  always_comb begin
    acc_nxt = acc;
    c_nxt   = c;
    case (func)
      SL_SHL: begin
        c_nxt   = acc[SL_DATA_W-1];
        acc_nxt = {acc[SL_DATA_W-2:0], 1'b0};
      end
      SL_ROL: begin
        c_nxt   = acc[SL_DATA_W-1];
        acc_nxt = {acc[SL_DATA_W-2:0], acc[SL_DATA_W-1]};
      end
      SL_RLC: begin
        c_nxt   = acc[SL_DATA_W-1];
        acc_nxt = {acc[SL_DATA_W-2:0], c};
      end
      default: begin
        acc_nxt = acc;
        c_nxt   = c;
      end
    endcase
    sign_chg = acc[SL_DATA_W-1] ^ acc_nxt[SL_DATA_W-1];
  end

endmodule

// File: rtl/cjb_8bit_sl_seq_unit_v.sv
// Sequential 8-bit shift-left / rotate-left / rotate-through-carry unit,
// one bit per clock under a Start/Done handshake. The result and CNVZ
// nibble are registered and only change in the DONE cycle.
// Optional feature macro: CJB_SL_ABORT_EN adds the Abort input, which
// cancels an operation in LOAD or SHIFT without a Done pulse.
// Handshake: Start is sampled only in IDLE; Busy is high in LOAD, SHIFT
// and DONE; Done is a one-cycle pulse in the DONE state, from which
// SL_Result/SL_CNVZ are valid and held until the next Done.
module cjb_8bit_sl_seq_unit_v
  import cjb_8bit_sl_seq_unit_v_pkg::*;
(
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Start,
  input  logic [1:0]           Func_Sel,
  input  logic [SL_DATA_W-1:0] Operand_X,
  input  logic [SL_DATA_W-1:0] Operand_Y,
  input  logic [SL_K_W-1:0]    Const_K,
  input  logic                 cin,
`ifdef CJB_SL_ABORT_EN
  input  logic                 Abort,
`endif
  output logic                 Busy,
  output logic                 Done,
  output logic [SL_DATA_W-1:0] SL_Result,
  output logic [3:0]           SL_CNVZ,
  output logic [1:0]           dbg_state
);

  localparam logic [SL_K_W-1:0] K_ONE = SL_K_W'(1);

  sl_state_e             state;
  sl_func_e              func_q;
  sl_func_e              func_in;
  logic [SL_DATA_W-1:0]  acc_q;
  logic                  c_q;
  logic                  v_q;
  logic [SL_K_W-1:0]     cnt_q;

  logic [SL_DATA_W-1:0]  acc_nxt;
  logic                  c_nxt;
  logic                  sign_chg;
  logic                  v_nxt;
  logic [SL_DATA_W-1:0]  direct_res;
  logic                  abort_hit;

  assign dbg_state = state;
  assign func_in   = sl_func_e'(Func_Sel);

  cjb_sl_step_v u_step (
    .acc      (acc_q),
    .c        (c_q),
    .func     (func_q),
    .acc_nxt  (acc_nxt),
    .c_nxt    (c_nxt),
    .sign_chg (sign_chg)
  );

  // Overflow is a sticky bit-7 change, meaningful only for plain shift.
  assign v_nxt = (func_q == SL_SHL) & (v_q | sign_chg);

  // Result when no stepping is needed: K=0 returns X, pass returns Y.
  always_comb begin
    direct_res = Operand_X;
    if (func_in == SL_PASS) direct_res = Operand_Y;
  end

  // Abort request, tied off when the feature is not built.
  always_comb begin
`ifdef CJB_SL_ABORT_EN
    abort_hit = Abort;
`else
    abort_hit = 1'b0;
`endif
  end

  // Control FSM, step counter, working registers and registered outputs.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      SL_Result <= '0;
      SL_CNVZ   <= '0;
      acc_q     <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      func_q    <= SL_SHL;
      cnt_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            state <= ST_LOAD;
            Busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (abort_hit) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            acc_q  <= Operand_X;
            c_q    <= cin;
            v_q    <= 1'b0;
            func_q <= func_in;
            cnt_q  <= Const_K;
            if ((Const_K != '0) && (func_in != SL_PASS)) begin
              state <= ST_SHIFT;
            end else begin
              state     <= ST_DONE;
              Done      <= 1'b1;
              SL_Result <= direct_res;
              SL_CNVZ   <= make_cnvz(cin, direct_res, 1'b0);
            end
          end
        end
        ST_SHIFT: begin
          if (abort_hit) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else begin
            acc_q <= acc_nxt;
            c_q   <= c_nxt;
            v_q   <= v_nxt;
            cnt_q <= cnt_q - K_ONE;
            if (cnt_q == K_ONE) begin
              state     <= ST_DONE;
              Done      <= 1'b1;
              SL_Result <= acc_nxt;
              SL_CNVZ   <= make_cnvz(c_nxt, acc_nxt, v_nxt);
            end
          end
        end
        ST_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cjb_8bit_sl_seq_unit_v.sv
// Bench for cjb_8bit_sl_seq_unit_v: directed and random operations against
// an arithmetic reference model, with a per-cycle compare of Busy, Done,
// SL_Result and SL_CNVZ.
module tb_cjb_8bit_sl_seq_unit_v;

  // ---------------- clock / reset ----------------
  logic       Clock  = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start  = 1'b0;
  logic [1:0] Func_Sel = 2'b00;
  logic [7:0] Operand_X = 8'h00;
  logic [7:0] Operand_Y = 8'h00;
  logic [2:0] Const_K = 3'd0;
  logic       cin = 1'b0;
`ifdef CJB_SL_ABORT_EN
  logic       Abort = 1'b0;
`endif
  logic       Busy;
  logic       Done;
  logic [7:0] SL_Result;
  logic [3:0] SL_CNVZ;
  logic [1:0] dbg_state;

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  cjb_8bit_sl_seq_unit_v dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Func_Sel  (Func_Sel),
    .Operand_X (Operand_X),
    .Operand_Y (Operand_Y),
    .Const_K   (Const_K),
    .cin       (cin),
`ifdef CJB_SL_ABORT_EN
    .Abort     (Abort),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .SL_Result (SL_Result),
    .SL_CNVZ   (SL_CNVZ),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Returns {result[7:0], C, N, V, Z} for a whole operation.
  function automatic logic [11:0] ref_op(input logic [1:0] f, input logic [7:0] x,
                                         input logic [7:0] y, input int k, input logic ci);
    logic [7:0] res;
    logic       c;
    logic       v;
    int         xi;
    int         nine;
    xi  = int'(x);
    res = x;
    c   = ci;
    v   = 1'b0;
    if (f == 2'b11) begin
      res = y;
    end else if (k > 0) begin
      case (f)
        2'b00: begin
          res = 8'((xi << k) & 255);
          c   = x[8-k];
          for (int i = 1; i <= k; i++) if (x[7-i] != x[7]) v = 1'b1;
        end
        2'b01: begin
          res = 8'(((xi << k) | (xi >> (8 - k))) & 255);
          c   = res[0];
        end
        default: begin
          nine = (int'(ci) << 8) | xi;
          nine = ((nine << k) | (nine >> (9 - k))) & 511;
          res  = 8'(nine & 255);
          c    = ((nine >> 8) & 1) != 0;
        end
      endcase
    end
    return {res, c, res[7], v, (res == 8'h00)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  logic [11:0] held = 12'h000;
  bit   m_active   = 1'b0;
  bit   m_has_done = 1'b0;
  int   m_start    = 0;
  int   m_end      = 0;
  int   last_done_cyc = -1;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare of handshake and held outputs against the model.
  always @(negedge Clock) begin
    if (cmp_en) begin
      bit exp_busy;
      bit exp_done;
      exp_busy = m_active && (cyc > m_start) && (cyc <= m_end);
      exp_done = m_active && m_has_done && (cyc == m_end);
      if (Done === 1'b1) last_done_cyc = cyc;
      check("busy", 32'(Busy), 32'(exp_busy));
      check("done", 32'(Done), 32'(exp_done));
      if (exp_done && exp_q.size() > 0) held = exp_q.pop_front();
      check("sl_result", 32'(SL_Result), 32'(held[11:4]));
      check("sl_cnvz", 32'(SL_CNVZ), 32'(held[3:0]));
      if (m_active && cyc >= m_end) m_active = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Raise Start for one cycle, hold operands through LOAD, then scramble them.
  task automatic issue(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y,
                       input int k, input logic ci);
    int lat;
    @(posedge Clock); #1;
    Func_Sel  = f;
    Operand_X = x;
    Operand_Y = y;
    Const_K   = 3'(k);
    cin       = ci;
    Start     = 1'b1;
    lat = (k == 0 || f == 2'b11) ? 2 : k + 2;
    m_start    = cyc;
    m_end      = cyc + lat;
    m_has_done = 1'b1;
    m_active   = 1'b1;
    exp_q.push_back(ref_op(f, x, y, k, ci));
    @(posedge Clock); #1;
    Start = 1'b0;
    @(posedge Clock); #1;
    Func_Sel  = 2'($urandom_range(0, 3));
    Operand_X = 8'($urandom_range(0, 255));
    Operand_Y = 8'($urandom_range(0, 255));
    Const_K   = 3'($urandom_range(0, 7));
    cin       = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_active && n < 50) begin
      @(negedge Clock);
      n++;
    end
    check("op_timeout", 32'(m_active), 32'd0);
    m_active = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] f, input logic [7:0] x, input logic [7:0] y,
                        input int k, input logic ci);
    issue(f, x, y, k, ci);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    cmp_en = 1'b1;

    // model pinned to hand-computed values
    check("model_shl81", 32'(ref_op(2'b00, 8'h81, 8'h00, 1, 1'b0)), 32'h02A);
    check("model_rol81", 32'(ref_op(2'b01, 8'h81, 8'h00, 1, 1'b0)), 32'h038);
    check("model_rlc80", 32'(ref_op(2'b10, 8'h80, 8'h00, 2, 1'b0)), 32'h010);
    check("model_pass",  32'(ref_op(2'b11, 8'h12, 8'hF0, 5, 1'b0)), 32'hF04);

    // directed operations with literal expectations
    run_op(2'b00, 8'h81, 8'h00, 1, 1'b0);
    check("shl_lit_res", 32'(SL_Result), 32'h02);
    check("shl_lit_cnvz", 32'(SL_CNVZ), 32'hA);
    check("shl_latency", 32'(last_done_cyc - m_start), 32'd3);

    run_op(2'b01, 8'h81, 8'h00, 1, 1'b0);
    check("rol_lit_res", 32'(SL_Result), 32'h03);
    check("rol_lit_cnvz", 32'(SL_CNVZ), 32'h8);

    run_op(2'b10, 8'h80, 8'h00, 2, 1'b0);
    check("rlc_lit_res", 32'(SL_Result), 32'h01);
    check("rlc_lit_cnvz", 32'(SL_CNVZ), 32'h0);
    check("rlc_latency", 32'(last_done_cyc - m_start), 32'd4);

    run_op(2'b00, 8'h00, 8'h00, 0, 1'b1);
    check("k0_lit_res", 32'(SL_Result), 32'h00);
    check("k0_lit_cnvz", 32'(SL_CNVZ), 32'h9);
    check("k0_latency", 32'(last_done_cyc - m_start), 32'd2);

    run_op(2'b11, 8'h33, 8'hF0, 3, 1'b0);
    check("pass_lit_res", 32'(SL_Result), 32'hF0);
    check("pass_lit_cnvz", 32'(SL_CNVZ), 32'h4);

    // Start during SHIFT of a K=7 shift is ignored
    issue(2'b00, 8'hB5, 8'h00, 7, 1'b0);
    @(posedge Clock); #1;
    Start     = 1'b1;
    Operand_X = 8'hFF;
    Func_Sel  = 2'b01;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_idle();
    check("k7_latency", 32'(last_done_cyc - m_start), 32'd9);
    check("k7_lit_res", 32'(SL_Result), 32'h80);

    // reset during SHIFT: back to reset values, no Done
    issue(2'b01, 8'h5A, 8'h00, 5, 1'b1);
    Resetn   = 1'b0;
    m_active = 1'b0;
    exp_q.delete();
    held = 12'h000;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(negedge Clock);
    check("rst_result", 32'(SL_Result), 32'h00);

`ifdef CJB_SL_ABORT_EN
    // abort during SHIFT keeps the previous result
    run_op(2'b00, 8'h0F, 8'h00, 2, 1'b0);
    issue(2'b00, 8'hC3, 8'h00, 6, 1'b0);
    Abort = 1'b1;
    m_end = cyc;
    m_has_done = 1'b0;
    void'(exp_q.pop_back());
    @(posedge Clock); #1;
    Abort = 1'b0;
    wait_idle();
    check("abort_keep_res", 32'(SL_Result), 32'h3C);
`endif

    // random operations, including back-to-back starts
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             8'($urandom_range(0, 255)), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge Clock);
    end

    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
